pmem_arbiter: RTL and testbench

// - Two-client arbiter directly upstream of physical memory: merges I-cache line fills and
//   D-cache fills/write-backs onto the single 256-bit line port of physical memory.
// - One memory transaction in flight; round-robin grant; address/wdata latched at grant.
// - Routes the memory response back to the granted client only.

---
 rtl/pmem_arbiter.sv | 126 ++++++++++++
 tb/tb_pmem_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// pmem_arbiter
//   Two-client arbiter in front of physical memory. It merges I-cache line
//   fills and D-cache fills/write-backs onto the single line port of memory.
//   Only one memory transaction is in flight at a time. Grants alternate
//   round-robin when both clients request together. The winner's address and
//   write data are latched at grant. The memory response is routed only to the
//   client that holds the grant.
//
// Ports
//   clk, rst                    clock; synchronous active-high reset
//   i_read, i_address           I-cache line read request (held until i_resp)
//   i_resp, i_rdata             I-cache one-cycle completion and fill data
//   d_read, d_write, d_address  D-cache request (held until d_resp)
//   d_wdata                     D-cache write-back data
//   d_resp, d_rdata             D-cache one-cycle completion and fill data
//   pmem_read, pmem_write       memory strobes (decoded from registered state)
//   pmem_address, pmem_wdata    registered copy of the granted request
//   pmem_resp, pmem_rdata       memory one-cycle completion and read data
module pmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t state, state_next;

  logic last_grant_d;  // 1 when the most recent grant went to the D-cache
  logic wr_lat;        // latched transaction type of the current D grant
  logic d_req;
  logic grant_i;
  logic grant_d;

  assign d_req = d_read | d_write;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    unique case (state)
      IDLE: begin
        // D wins when it is the only requester, or on a tie when I was
        // served last. Otherwise I wins whenever it is requesting.
        if (d_req && (!i_read || !last_grant_d)) begin
          grant_d    = 1'b1;
          state_next = GRANT_D;
        end else if (i_read) begin
          grant_i    = 1'b1;
          state_next = GRANT_I;
        end
      end
      GRANT_I, GRANT_D: begin
        if (pmem_resp) state_next = RECOVER;
      end
      RECOVER: state_next = IDLE;  // memory needs one idle cycle after resp
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments, so every
  // flop samples pre-edge values regardless of the order of the statements.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Request capture happens only on the grant edge. Later changes on the
  // client address and data lines are ignored until the next grant.
  // NOTE: the wide address and data registers are reset explicitly, because
  // they drive module outputs that must read zero straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pmem_address <= '0;
      pmem_wdata   <= '0;
      wr_lat       <= 1'b0;
      last_grant_d <= 1'b0;
    end else if (grant_d) begin
      pmem_address <= d_address;
      pmem_wdata   <= d_wdata;
      wr_lat       <= d_write;  // a write-back wins when read and write are both high
      last_grant_d <= 1'b1;
    end else if (grant_i) begin
      pmem_address <= i_address;
      wr_lat       <= 1'b0;
      last_grant_d <= 1'b0;
    end
  end

  // The strobes are pure decodes of registered state, so they stay stable for
  // the whole grant and can never be high together.
  assign pmem_read  = (state == GRANT_I) || ((state == GRANT_D) && !wr_lat);
  assign pmem_write = (state == GRANT_D) && wr_lat;

  // A completion that arrives while reset is asserted is abandoned.
  assign i_resp  = (state == GRANT_I) && pmem_resp && !rst;
  assign d_resp  = (state == GRANT_D) && pmem_resp && !rst;
  assign i_rdata = i_resp ? pmem_rdata : '0;
  assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter
//   Directed bench for pmem_arbiter. It covers reset, a single I read, a
//   single D write, tie arbitration, back-to-back I reads, reset during a
//   grant, a combined D read+write with the address changed mid-grant, and a
//   memory response that arrives outside any grant. Inputs change 1 ns after
//   the rising edge. Outputs are sampled before the next edge.
module tb_pmem_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic              i_resp;
  logic [LINE_W-1:0] i_rdata;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic              d_resp;
  logic [LINE_W-1:0] d_rdata;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_resp;
  logic [LINE_W-1:0] pmem_rdata;

  int checks = 0;
  int errors = 0;

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    checks++;
    if ({pmem_read, pmem_write} !== 2'b00) begin
      errors++; $display("FAIL reset_strobes: got %b expected 00", {pmem_read, pmem_write});
    end
    checks++;
    if (pmem_address !== 16'h0000) begin
      errors++; $display("FAIL reset_address: got %h expected 0000", pmem_address);
    end
    checks++;
    if (pmem_wdata !== '0) begin
      errors++; $display("FAIL reset_wdata: got %h expected 0", pmem_wdata);
    end
    checks++;
    if ({i_resp, d_resp, |i_rdata, |d_rdata} !== 4'b0000) begin
      errors++; $display("FAIL reset_resp: got %b expected 0000", {i_resp, d_resp, |i_rdata, |d_rdata});
    end
    rst = 1'b0;
  endtask

  task automatic test_i_read();
    logic [LINE_W-1:0] line_a5;
    line_a5 = {32{8'hA5}};
    i_read = 1'b1; i_address = 16'h0040;
    tick();
    checks++;
    if ({pmem_read, pmem_write} !== 2'b10) begin
      errors++; $display("FAIL iread_strobes: got %b expected 10", {pmem_read, pmem_write});
    end
    checks++;
    if (pmem_address !== 16'h0040) begin
      errors++; $display("FAIL iread_address: got %h expected 0040", pmem_address);
    end
    pmem_resp = 1'b1; pmem_rdata = line_a5;
    #1;
    checks++;
    if ({i_resp, d_resp} !== 2'b10) begin
      errors++; $display("FAIL iread_resp: got %b expected 10", {i_resp, d_resp});
    end
    checks++;
    if (i_rdata !== line_a5) begin
      errors++; $display("FAIL iread_rdata: got %h expected %h", i_rdata, line_a5);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if ({pmem_read, pmem_write, i_resp} !== 3'b000) begin
      errors++; $display("FAIL iread_recover: got %b expected 000", {pmem_read, pmem_write, i_resp});
    end
    tick();
  endtask

  task automatic test_d_write();
    logic [LINE_W-1:0] wline;
    logic [LINE_W-1:0] rline;
    wline = {8{32'h12345678}};
    rline = {8{32'hDEADBEEF}};
    d_write = 1'b1; d_address = 16'h1F20; d_wdata = wline;
    tick();
    checks++;
    if ({pmem_read, pmem_write} !== 2'b01) begin
      errors++; $display("FAIL dwrite_strobes: got %b expected 01", {pmem_read, pmem_write});
    end
    checks++;
    if (pmem_address !== 16'h1F20) begin
      errors++; $display("FAIL dwrite_address: got %h expected 1f20", pmem_address);
    end
    checks++;
    if (pmem_wdata !== wline) begin
      errors++; $display("FAIL dwrite_wdata: got %h expected %h", pmem_wdata, wline);
    end
    pmem_resp = 1'b1; pmem_rdata = rline;
    #1;
    checks++;
    if ({i_resp, d_resp} !== 2'b01) begin
      errors++; $display("FAIL dwrite_resp: got %b expected 01", {i_resp, d_resp});
    end
    checks++;
    if (i_rdata !== '0) begin
      errors++; $display("FAIL dwrite_irdata: got %h expected 0", i_rdata);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
      errors++; $display("FAIL dwrite_recover: got %b expected 0000", {pmem_read, pmem_write, i_resp, d_resp});
    end
    tick();
  endtask

  task automatic test_arbitration();
    logic              exp_d;
    logic [LINE_W-1:0] rline;
    apply_reset();
    i_read = 1'b1; i_address = 16'h0100;
    d_read = 1'b1; d_address = 16'h0200;
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2 == 0);  // reset leaves I as last grant, so D goes first
      rline = {64{4'(k + 1)}};
      tick();
      checks++;
      if ({pmem_read, pmem_write} !== 2'b10) begin
        errors++; $display("FAIL arb%0d_strobes: got %b expected 10", k, {pmem_read, pmem_write});
      end
      checks++;
      if (pmem_address !== (exp_d ? 16'h0200 : 16'h0100)) begin
        errors++; $display("FAIL arb%0d_address: got %h expected %h", k, pmem_address, exp_d ? 16'h0200 : 16'h0100);
      end
      pmem_resp = 1'b1; pmem_rdata = rline;
      #1;
      checks++;
      if ({i_resp, d_resp} !== {~exp_d, exp_d}) begin
        errors++; $display("FAIL arb%0d_resp: got %b expected %b", k, {i_resp, d_resp}, {~exp_d, exp_d});
      end
      checks++;
      if ((exp_d ? d_rdata : i_rdata) !== rline) begin
        errors++; $display("FAIL arb%0d_rdata: got %h expected %h", k, exp_d ? d_rdata : i_rdata, rline);
      end
      tick();
      pmem_resp = 1'b0; pmem_rdata = '0;
      #1;
      checks++;
      if ({pmem_read, pmem_write} !== 2'b00) begin
        errors++; $display("FAIL arb%0d_recover: got %b expected 00", k, {pmem_read, pmem_write});
      end
      tick();
      checks++;
      if ({pmem_read, pmem_write} !== 2'b00) begin
        errors++; $display("FAIL arb%0d_idle: got %b expected 00", k, {pmem_read, pmem_write});
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    i_read = 1'b1; i_address = 16'h0400;
    tick();
    checks++;
    if ({pmem_read, pmem_address} !== {1'b1, 16'h0400}) begin
      errors++; $display("FAIL b2b_first: got %b/%h expected 1/0400", pmem_read, pmem_address);
    end
    pmem_resp = 1'b1; pmem_rdata = {16{16'h1111}};
    #1;
    checks++;
    if (i_resp !== 1'b1) begin
      errors++; $display("FAIL b2b_first_resp: got %b expected 1", i_resp);
    end
    i_address = 16'h0800;
    tick();
    pmem_resp = 1'b0;
    #1;
    checks++;
    if ({pmem_read, pmem_write} !== 2'b00) begin
      errors++; $display("FAIL b2b_gap_recover: got %b expected 00", {pmem_read, pmem_write});
    end
    tick();
    checks++;
    if ({pmem_read, pmem_write} !== 2'b00) begin
      errors++; $display("FAIL b2b_gap_idle: got %b expected 00", {pmem_read, pmem_write});
    end
    tick();
    checks++;
    if ({pmem_read, pmem_address} !== {1'b1, 16'h0800}) begin
      errors++; $display("FAIL b2b_second: got %b/%h expected 1/0800", pmem_read, pmem_address);
    end
    pmem_resp = 1'b1; pmem_rdata = {16{16'h2222}};
    #1;
    checks++;
    if (i_rdata !== {16{16'h2222}}) begin
      errors++; $display("FAIL b2b_second_rdata: got %h expected %h", i_rdata, {16{16'h2222}});
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_grant();
    d_read = 1'b1; d_address = 16'h0500;
    tick();
    checks++;
    if ({pmem_read, pmem_write} !== 2'b10) begin
      errors++; $display("FAIL rstmid_grant: got %b expected 10", {pmem_read, pmem_write});
    end
    rst = 1'b1; pmem_resp = 1'b1; pmem_rdata = {8{32'h55AA55AA}};
    #1;
    checks++;
    if (d_resp !== 1'b0) begin
      errors++; $display("FAIL rstmid_resp_in_reset: got %b expected 0", d_resp);
    end
    tick();
    checks++;
    if ({pmem_read, pmem_write, d_resp} !== 3'b000) begin
      errors++; $display("FAIL rstmid_after_edge: got %b expected 000", {pmem_read, pmem_write, d_resp});
    end
    checks++;
    if (pmem_address !== 16'h0000) begin
      errors++; $display("FAIL rstmid_address: got %h expected 0000", pmem_address);
    end
    rst = 1'b0;
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      pmem_resp = (k == 1);
      tick();
      checks++;
      if ({pmem_read, pmem_write, d_resp, i_resp} !== 4'b0000) begin
        errors++; $display("FAIL rstmid_quiet%0d: got %b expected 0000", k, {pmem_read, pmem_write, d_resp, i_resp});
      end
    end
    pmem_resp = 1'b0;
    i_read = 1'b1; i_address = 16'h0600;
    tick();
    checks++;
    if ({pmem_read, pmem_address} !== {1'b1, 16'h0600}) begin
      errors++; $display("FAIL rstmid_restart: got %b/%h expected 1/0600", pmem_read, pmem_address);
    end
    pmem_resp = 1'b1;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_read_write_both();
    logic [LINE_W-1:0] wline;
    wline = {8{32'hCAFEF00D}};
    d_read = 1'b1; d_write = 1'b1; d_address = 16'h0300; d_wdata = wline;
    tick();
    checks++;
    if ({pmem_read, pmem_write} !== 2'b01) begin
      errors++; $display("FAIL rw_strobes: got %b expected 01", {pmem_read, pmem_write});
    end
    d_address = 16'hABC0; d_wdata = '0;
    tick();
    checks++;
    if ({pmem_address, pmem_wdata} !== {16'h0300, wline}) begin
      errors++; $display("FAIL rw_latched: got %h/%h expected 0300/%h", pmem_address, pmem_wdata, wline);
    end
    d_read = 1'b0; d_write = 1'b0;  // client drops early; transaction must still finish
    tick();
    checks++;
    if ({pmem_read, pmem_write} !== 2'b01) begin
      errors++; $display("FAIL rw_dropped_hold: got %b expected 01", {pmem_read, pmem_write});
    end
    pmem_resp = 1'b1;
    #1;
    checks++;
    if ({i_resp, d_resp} !== 2'b01) begin
      errors++; $display("FAIL rw_resp: got %b expected 01", {i_resp, d_resp});
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_stray_resp();
    pmem_resp = 1'b1; pmem_rdata = {LINE_W{1'b1}};
    #1;
    checks++;
    if ({i_resp, d_resp, |i_rdata, |d_rdata} !== 4'b0000) begin
      errors++; $display("FAIL stray_resp: got %b expected 0000", {i_resp, d_resp, |i_rdata, |d_rdata});
    end
    tick();
    checks++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
      errors++; $display("FAIL stray_after: got %b expected 0000", {pmem_read, pmem_write, i_resp, d_resp});
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_arbitration();
    test_back_to_back();
    test_reset_mid_grant();
    test_read_write_both();
    test_stray_resp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
